// File: rtl/rfid_pkg.sv
// Shared definitions for the RFID sample FIFO: register map, bit positions
// and default geometry.
package rfid_pkg;

    localparam int unsigned DEPTH_DEF = 16;
    localparam int unsigned PTR_W_DEF = 4;

    typedef enum logic [2:0] {
        REG_DATA   = 3'd0,
        REG_STATUS = 3'd1,
        REG_CTRL   = 3'd2,
        REG_COUNT  = 3'd3,
        REG_THRESH = 3'd4
    } reg_addr_e;

    // STATUS register bit positions
    localparam int unsigned ST_EMPTY = 0;
    localparam int unsigned ST_FULL  = 1;
    localparam int unsigned ST_OVF   = 2;
    localparam int unsigned ST_EN    = 3;
    localparam int unsigned ST_INTA  = 4;

    // CTRL register bit positions
    localparam int unsigned CTRL_FLUSH   = 0;
    localparam int unsigned CTRL_CLR_OVF = 1;
    localparam int unsigned CTRL_EN      = 7;

endpackage

// File: rtl/rfid_sync_fifo.sv
// Byte-wide synchronous FIFO with first-word fall-through head, occupancy
// count and a synchronous flush that overrides any push/pop in the same cycle.
module rfid_sync_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned PTR_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [7:0]       wdata_i,
    output logic [7:0]       rdata_o,
    output logic [PTR_W:0]   count_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             ovf_evt_o
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [7:0]       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push;

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);
    assign w_pop   = pop_i & ~w_empty;
    // A push into a full FIFO is still accepted when a pop frees a slot that cycle
    assign w_push  = push_i & (~w_full | w_pop);

    assign full_o    = w_full;
    assign empty_o   = w_empty;
    assign count_o   = r_count;
    assign ovf_evt_o = push_i & w_full & ~w_pop & ~flush_i;
    assign rdata_o   = w_empty ? '0 : r_mem[r_rd_ptr];

    // Storage write; contents need no reset because the head is masked when empty
    always_ff @(posedge clk_i) begin
        if (w_push && !flush_i) begin
            r_mem[r_wr_ptr] <= wdata_i;
        end
    end

    // Pointer and occupancy tracking; flush takes priority over push/pop
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/rfid_sample_fifo.sv
// Wishbone-attached sample FIFO feeding the RFID backscatter encoder.
// Optional threshold interrupt and THRESH register: define RFID_SAMPLE_FIFO_IRQ_EN.
module rfid_sample_fifo
    import rfid_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned PTR_W = PTR_W_DEF
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       cyc_i,
    input  logic       stb_i,
    input  logic [2:0] adr_i,
    input  logic       we_i,
    input  logic [7:0] dat_i,
    output logic [7:0] dat_o,
    output logic       ack_o,
    output logic       inta_o,
    output logic [7:0] tx_data_o,
    output logic       tx_valid_o,
    input  logic       tx_ready_i
);

    logic       r_ack;
    logic [2:0] r_adr;
    logic       r_we;
    logic [7:0] r_dat;
    logic       r_en;
    logic       r_ovf;

    logic           w_access;
    logic           w_wr;
    logic           w_push;
    logic           w_pop;
    logic           w_flush;
    logic           w_clr_ovf;
    logic           w_ovf_evt;
    logic           w_full;
    logic           w_empty;
    logic [7:0]     w_head;
    logic [PTR_W:0] w_count;
    logic [7:0]     w_count8;
    logic [7:0]     w_status;
    logic [7:0]     w_rd;
    logic [7:0]     w_thresh;
    logic           w_inta;

    assign w_access  = cyc_i & stb_i & ~r_ack;
    // Register writes take effect at the end of the ack cycle using the latched request
    assign w_wr      = r_ack & r_we;
    assign w_push    = w_wr & (r_adr == REG_DATA) & r_en;
    assign w_flush   = w_wr & (r_adr == REG_CTRL) & r_dat[CTRL_FLUSH];
    assign w_clr_ovf = w_wr & (r_adr == REG_CTRL) & r_dat[CTRL_CLR_OVF];
    assign w_pop     = ~w_empty & tx_ready_i;
    assign w_count8  = 8'(w_count);

    rfid_sync_fifo #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push_i    (w_push),
        .pop_i     (w_pop),
        .flush_i   (w_flush),
        .wdata_i   (r_dat),
        .rdata_o   (w_head),
        .count_o   (w_count),
        .full_o    (w_full),
        .empty_o   (w_empty),
        .ovf_evt_o (w_ovf_evt)
    );

    // Single-cycle ack and capture of the request fields for the ack cycle
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_ack <= 1'b0;
            r_adr <= '0;
            r_we  <= 1'b0;
            r_dat <= '0;
        end else begin
            r_ack <= w_access;
            if (w_access) begin
                r_adr <= adr_i;
                r_we  <= we_i;
                r_dat <= dat_i;
            end
        end
    end

    // Enable and sticky overflow; an overflowing push beats a same-cycle clear
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_en  <= 1'b0;
            r_ovf <= 1'b0;
        end else begin
            if (w_wr && (r_adr == REG_CTRL)) begin
                r_en <= r_dat[CTRL_EN];
            end
            if (w_ovf_evt) begin
                r_ovf <= 1'b1;
            end else if (w_clr_ovf) begin
                r_ovf <= 1'b0;
            end
        end
    end

`ifdef RFID_SAMPLE_FIFO_IRQ_EN
    logic [7:0] r_thresh;
    logic       r_inta;

    // Threshold register and registered level interrupt
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_thresh <= '0;
            r_inta   <= 1'b0;
        end else begin
            if (w_wr && (r_adr == REG_THRESH)) begin
                r_thresh <= r_dat;
            end
            r_inta <= (w_count8 >= r_thresh) && (r_thresh != '0);
        end
    end

    assign w_thresh = r_thresh;
    assign w_inta   = r_inta;
`else
    assign w_thresh = '0;
    assign w_inta   = 1'b0;
`endif

    // Status word assembly and read-data mux for the latched address
    always_comb begin
        w_status           = '0;
        w_status[ST_EMPTY] = w_empty;
        w_status[ST_FULL]  = w_full;
        w_status[ST_OVF]   = r_ovf;
        w_status[ST_EN]    = r_en;
        w_status[ST_INTA]  = w_inta;
        w_rd               = '0;
        case (r_adr)
            REG_DATA:   w_rd = w_head;
            REG_STATUS: w_rd = w_status;
            REG_CTRL:   w_rd = {r_en, 7'b0};
            REG_COUNT:  w_rd = w_count8;
            REG_THRESH: w_rd = w_thresh;
            default:    w_rd = '0;
        endcase
    end

    assign dat_o      = r_ack ? w_rd : '0;
    assign ack_o      = r_ack;
    assign inta_o     = w_inta;
    assign tx_valid_o = ~w_empty;
    assign tx_data_o  = w_head;

endmodule

// File: tb/tb_rfid_sample_fifo.sv
// Self-checking bench for rfid_sample_fifo; handles both the default build
// and the RFID_SAMPLE_FIFO_IRQ_EN build.
module tb_rfid_sample_fifo;

    localparam int DEPTH = 16;
`ifdef RFID_SAMPLE_FIFO_IRQ_EN
    localparam bit IRQ = 1'b1;
`else
    localparam bit IRQ = 1'b0;
`endif

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic       cyc_i = 1'b0;
    logic       stb_i = 1'b0;
    logic [2:0] adr_i = '0;
    logic       we_i = 1'b0;
    logic [7:0] dat_i = '0;
    logic [7:0] dat_o;
    logic       ack_o;
    logic       inta_o;
    logic [7:0] tx_data_o;
    logic       tx_valid_o;
    logic       tx_ready_i = 1'b0;

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [7:0] q[$];
    logic       m_en = 1'b0;
    logic       m_ovf = 1'b0;
    logic [7:0] m_thresh = '0;

    rfid_sample_fifo dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .cyc_i      (cyc_i),
        .stb_i      (stb_i),
        .adr_i      (adr_i),
        .we_i       (we_i),
        .dat_i      (dat_i),
        .dat_o      (dat_o),
        .ack_o      (ack_o),
        .inta_o     (inta_o),
        .tx_data_o  (tx_data_o),
        .tx_valid_o (tx_valid_o),
        .tx_ready_i (tx_ready_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] exp_status();
        logic irq;
        irq = IRQ && (m_thresh != 0) && (q.size() >= int'(m_thresh));
        return {3'b000, irq, m_en, m_ovf, q.size() == DEPTH, q.size() == 0};
    endfunction

    function automatic logic [7:0] exp_read(input logic [2:0] a);
        case (a)
            3'd0:    return (q.size() > 0) ? q[0] : 8'h00;
            3'd1:    return exp_status();
            3'd2:    return {m_en, 7'b0};
            3'd3:    return 8'(q.size());
            3'd4:    return IRQ ? m_thresh : 8'h00;
            default: return 8'h00;
        endcase
    endfunction

    // One Wishbone transfer; optionally holds tx_ready_i high during the ack cycle
    task automatic wb_xfer(input logic [2:0] a, input logic w, input logic [7:0] d,
                           input logic ra, output logic [7:0] rd);
        int n;
        n = 0;
        cyc_i = 1'b1; stb_i = 1'b1; adr_i = a; we_i = w; dat_i = d;
        do begin
            @(posedge clk_i); #1;
            n++;
        end while (ack_o !== 1'b1 && n < 8);
        tests++;
        if (n != 1 || ack_o !== 1'b1) begin
            fails++;
            $display("FAIL ack_latency adr=%0d: ack seen after %0d cycles (ack=%b), required 1", a, n, ack_o);
        end
        rd = dat_o;
        tx_ready_i = ra;
        @(posedge clk_i); #1;
        tx_ready_i = 1'b0;
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        tests++;
        if (ack_o !== 1'b0 || dat_o !== 8'h00) begin
            fails++;
            $display("FAIL ack_release adr=%0d: ack=%b dat_o=%h, required ack=0 dat_o=00", a, ack_o, dat_o);
        end
    endtask

    // Write with model update (pop-in-ack, overflow, flush priority)
    task automatic wb_write(input logic [2:0] a, input logic [7:0] d, input logic ra);
        logic [7:0] rd;
        bit pop;
        wb_xfer(a, 1'b1, d, ra, rd);
        pop = ra && q.size() > 0;
        if (a == 3'd0 && m_en && q.size() == DEPTH && !pop) m_ovf = 1'b1;
        if (pop) void'(q.pop_front());
        if (a == 3'd0 && m_en && q.size() < DEPTH) q.push_back(d);
        if (a == 3'd2) begin
            if (d[0]) q.delete();
            if (d[1]) m_ovf = 1'b0;
            m_en = d[7];
        end
        if (a == 3'd4 && IRQ) m_thresh = d;
    endtask

    task automatic wb_read_check(input logic [2:0] a, input string nm);
        logic [7:0] rd;
        logic [7:0] exp;
        exp = exp_read(a);
        wb_xfer(a, 1'b0, 8'h00, 1'b0, rd);
        tests++;
        if (rd !== exp) begin
            fails++;
            $display("FAIL %s adr=%0d: got %h, required %h", nm, a, rd, exp);
        end
    endtask

    // Drain the FIFO with random ready, comparing every offered byte with the model
    task automatic drain(input string nm);
        int  n;
        logic r;
        n = 0;
        while (q.size() > 0 && n < 400) begin
            tests++;
            if (tx_valid_o !== 1'b1 || tx_data_o !== q[0]) begin
                fails++;
                $display("FAIL %s_byte: valid=%b data=%h, required valid=1 data=%h", nm, tx_valid_o, tx_data_o, q[0]);
            end
            r = 1'($urandom_range(0, 1));
            tx_ready_i = r;
            @(posedge clk_i); #1;
            n++;
            if (r) void'(q.pop_front());
        end
        tx_ready_i = 1'b0;
        tests++;
        if (q.size() != 0 || tx_valid_o !== 1'b0) begin
            fails++;
            $display("FAIL %s_empty: valid=%b model_left=%0d, required valid=0 model_left=0", nm, tx_valid_o, q.size());
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        #1;
        tests++;
        if (dat_o !== 8'h00 || ack_o !== 1'b0 || inta_o !== 1'b0 || tx_valid_o !== 1'b0 || tx_data_o !== 8'h00) begin
            fails++;
            $display("FAIL reset_outputs: dat=%h ack=%b inta=%b valid=%b data=%h, required all 0",
                     dat_o, ack_o, inta_o, tx_valid_o, tx_data_o);
        end
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        wb_read_check(3'd1, "reset_status");
        wb_read_check(3'd3, "reset_count");
        wb_read_check(3'd2, "reset_ctrl");
    endtask

    task automatic test_basic();
        wb_write(3'd2, 8'h80, 1'b0);
        wb_write(3'd0, 8'h0A, 1'b0);
        wb_write(3'd0, 8'h2D, 1'b0);
        wb_write(3'd0, 8'h02, 1'b0);
        wb_read_check(3'd3, "basic_count");
        wb_read_check(3'd1, "basic_status");
        wb_read_check(3'd0, "basic_head");
        wb_read_check(3'd3, "basic_count_no_pop");
        drain("basic_drain");
        // writes ignored while disabled
        wb_write(3'd2, 8'h00, 1'b0);
        wb_write(3'd0, 8'h99, 1'b0);
        wb_read_check(3'd3, "disabled_count");
        tests++;
        if (tx_valid_o !== 1'b0) begin
            fails++;
            $display("FAIL disabled_valid: got %b, required 0", tx_valid_o);
        end
    endtask

    task automatic test_overflow();
        wb_write(3'd2, 8'h83, 1'b0);
        for (int i = 0; i < DEPTH; i++) wb_write(3'd0, 8'($urandom), 1'b0);
        wb_read_check(3'd3, "ovf_count_full");
        wb_read_check(3'd1, "ovf_status_full");
        wb_write(3'd0, 8'h55, 1'b0);
        wb_read_check(3'd1, "ovf_status_overflow");
        wb_read_check(3'd3, "ovf_count_after_drop");
        wb_write(3'd2, 8'h82, 1'b0);
        wb_read_check(3'd1, "ovf_status_cleared");
        wb_read_check(3'd3, "ovf_count_cleared");
    endtask

    task automatic test_full_push_pop();
        wb_write(3'd0, 8'h77, 1'b1);
        wb_read_check(3'd3, "fullpp_count");
        wb_read_check(3'd1, "fullpp_status");
        drain("fullpp_drain");
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) wb_write(3'd0, 8'($urandom), 1'b0);
        wb_write(3'd2, 8'h81, 1'b1);
        tests++;
        if (tx_valid_o !== 1'b0) begin
            fails++;
            $display("FAIL flush_valid: got %b, required 0", tx_valid_o);
        end
        wb_read_check(3'd3, "flush_count");
        wb_read_check(3'd1, "flush_status");
        wb_write(3'd0, 8'h3C, 1'b0);
        wb_read_check(3'd3, "flush_then_push_count");
        drain("flush_drain");
    endtask

    task automatic test_irq();
        wb_write(3'd2, 8'h83, 1'b0);
        wb_write(3'd4, 8'h04, 1'b0);
        wb_read_check(3'd4, "irq_thresh_read");
        for (int i = 0; i < 3; i++) wb_write(3'd0, 8'($urandom), 1'b0);
        tests++;
        if (inta_o !== 1'b0) begin
            fails++;
            $display("FAIL irq_below: got %b, required 0", inta_o);
        end
        wb_write(3'd0, 8'hE1, 1'b0);
        tests++;
        if (inta_o !== 1'b0) begin
            fails++;
            $display("FAIL irq_lag: got %b on push edge, required 0", inta_o);
        end
        @(posedge clk_i); #1;
        tests++;
        if (inta_o !== IRQ) begin
            fails++;
            $display("FAIL irq_assert: got %b, required %b", inta_o, IRQ);
        end
        wb_read_check(3'd1, "irq_status");
        tx_ready_i = 1'b1;
        @(posedge clk_i); #1;
        tx_ready_i = 1'b0;
        void'(q.pop_front());
        @(posedge clk_i); #1;
        tests++;
        if (inta_o !== 1'b0) begin
            fails++;
            $display("FAIL irq_deassert: got %b, required 0", inta_o);
        end
        wb_read_check(3'd1, "irq_status_after_pop");
        wb_write(3'd4, 8'h00, 1'b0);
        drain("irq_drain");
    endtask

    task automatic test_random();
        logic [7:0] d;
        int op;
        for (int round = 0; round < 6; round++) begin
            for (int k = 0; k < 30; k++) begin
                op = $urandom_range(0, 9);
                d = 8'($urandom);
                if (op <= 5) begin
                    wb_write(3'd0, d, 1'b0);
                end else if (op == 6) begin
                    if ($urandom_range(0, 4) != 0) d[0] = 1'b0;
                    if ($urandom_range(0, 3) != 0) d[7] = 1'b1;
                    wb_write(3'd2, d, 1'b0);
                end else if (op == 7 || op == 8) begin
                    wb_read_check(3'($urandom_range(0, 7)), "rand_read");
                end else begin
                    wb_write(3'($urandom_range(4, 7)), 8'($urandom_range(0, 20)), 1'b0);
                end
            end
            wb_read_check(3'd1, "rand_status");
            wb_read_check(3'd3, "rand_count");
            drain("rand_drain");
        end
    endtask

    task automatic test_reset_midstream();
        wb_write(3'd2, 8'h80, 1'b0);
        for (int i = 0; i < 5; i++) wb_write(3'd0, 8'($urandom), 1'b0);
        cyc_i = 1'b1; stb_i = 1'b1; adr_i = 3'd3; we_i = 1'b0;
        @(posedge clk_i); #2;
        rst_i = 1'b0;
        #1;
        tests++;
        if (ack_o !== 1'b0 || tx_valid_o !== 1'b0 || tx_data_o !== 8'h00 || dat_o !== 8'h00) begin
            fails++;
            $display("FAIL midreset_async: ack=%b valid=%b data=%h dat=%h, required all 0",
                     ack_o, tx_valid_o, tx_data_o, dat_o);
        end
        cyc_i = 1'b0; stb_i = 1'b0;
        q.delete(); m_en = 1'b0; m_ovf = 1'b0; m_thresh = '0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        wb_read_check(3'd3, "midreset_count");
        wb_read_check(3'd1, "midreset_status");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_full_push_pop();
        test_flush();
        test_irq();
        test_random();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
